// File: rtl/bus_arbiter_3w.sv
// rtl/bus_arbiter_3w.sv - BR/BG/BGACK grant-side arbiter for two local DMA masters
// Optional tie-break rotation: define BUS_ARB_ROUND_ROBIN_EN (default build is fixed priority, master 0).
module bus_arbiter_3w #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       C7M,
    input  logic       RESET_n,
    input  logic       AS_n,
    input  logic [1:0] BR_n,
    input  logic       BGACK_n,
    output logic [1:0] BG_n,
    output logic       CPU_OWNS_BUS,
    output logic       OWNER,
    output logic       GRANT_TIMEOUT
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_AS = 3'd1,
        GRANT   = 3'd2,
        OWNED   = 3'd3,
        RECOVER = 3'd4
    } state_t;

    // The timeout decision is taken on the cycle the counter is about to reach the limit,
    // so BG_n stays low for exactly TIMEOUT_CYCLES cycles.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state, state_next;
    logic [1:0] br_m, br_s;
    logic       bgack_m, bgack_s;
    logic [7:0] cnt, cnt_next;
    logic [1:0] bg_next;
    logic       cpu_next;
    logic       owner_next;
    logic       gt_next;
    logic       winner;
    logic       tie_pick;
    logic [1:0] grant_mask;

    always_ff @(posedge C7M or negedge RESET_n) begin
        if (!RESET_n) begin
            br_m    <= 2'b11;
            br_s    <= 2'b11;
            bgack_m <= 1'b1;
            bgack_s <= 1'b1;
        end else begin
            br_m    <= BR_n;
            br_s    <= br_m;
            bgack_m <= BGACK_n;
            bgack_s <= bgack_m;
        end
    end

`ifdef BUS_ARB_ROUND_ROBIN_EN
    logic rr_ptr, rr_ptr_next;

    always_ff @(posedge C7M or negedge RESET_n) begin
        if (!RESET_n) begin
            rr_ptr <= 1'b0;
        end else begin
            rr_ptr <= rr_ptr_next;
        end
    end

    // The pointer only advances once a master has actually held the bus.
    always_comb begin
        rr_ptr_next = rr_ptr;
        if (state == OWNED && bgack_s) begin
            rr_ptr_next = ~OWNER;
        end
    end

    assign tie_pick = rr_ptr;
`else
    assign tie_pick = 1'b0;
`endif

    always_comb begin
        if (br_s == 2'b00) begin
            winner = tie_pick;
        end else begin
            winner = br_s[0];
        end
    end

    assign grant_mask = OWNER ? 2'b01 : 2'b10;

    always_comb begin
        state_next = state;
        owner_next = OWNER;
        bg_next    = 2'b11;
        cpu_next   = 1'b1;
        gt_next    = 1'b0;
        cnt_next   = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
        case (state)
            IDLE: begin
                if (br_s != 2'b11) begin
                    owner_next = winner;
                    state_next = WAIT_AS;
                end
            end
            WAIT_AS: begin
                if (AS_n) begin
                    state_next = GRANT;
                    bg_next    = grant_mask;
                    cnt_next   = 8'd0;
                end
            end
            GRANT: begin
                if (!bgack_s) begin
                    state_next = OWNED;
                    cpu_next   = 1'b0;
                end else if (br_s[OWNER]) begin
                    state_next = IDLE;
                end else if (cnt >= TIMEOUT_LAST) begin
                    state_next = IDLE;
                    gt_next    = 1'b1;
                end else begin
                    bg_next = grant_mask;
                end
            end
            OWNED: begin
                cpu_next = 1'b0;
                if (bgack_s) begin
                    state_next = RECOVER;
                end
            end
            RECOVER: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge C7M or negedge RESET_n) begin
        if (!RESET_n) begin
            state         <= IDLE;
            cnt           <= 8'd0;
            BG_n          <= 2'b11;
            CPU_OWNS_BUS  <= 1'b1;
            OWNER         <= 1'b0;
            GRANT_TIMEOUT <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            BG_n          <= bg_next;
            CPU_OWNS_BUS  <= cpu_next;
            OWNER         <= owner_next;
            GRANT_TIMEOUT <= gt_next;
        end
    end

endmodule

// File: tb/tb_bus_arbiter_3w.sv
// tb/tb_bus_arbiter_3w.sv - directed self-checking bench for bus_arbiter_3w
module tb_bus_arbiter_3w;

    logic       C7M;
    logic       RESET_n;
    logic       AS_n;
    logic [1:0] BR_n;
    logic       BGACK_n;
    logic [1:0] BG_n;
    logic       CPU_OWNS_BUS;
    logic       OWNER;
    logic       GRANT_TIMEOUT;

    int tests;
    int fails;

    bus_arbiter_3w #(.TIMEOUT_CYCLES(16)) dut (
        .C7M          (C7M),
        .RESET_n      (RESET_n),
        .AS_n         (AS_n),
        .BR_n         (BR_n),
        .BGACK_n      (BGACK_n),
        .BG_n         (BG_n),
        .CPU_OWNS_BUS (CPU_OWNS_BUS),
        .OWNER        (OWNER),
        .GRANT_TIMEOUT(GRANT_TIMEOUT)
    );

    initial C7M = 1'b0;
    always #5 C7M = ~C7M;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge C7M);
            #1;
        end
    endtask

    task automatic test_reset;
        RESET_n = 1'b0; AS_n = 1'b1; BR_n = 2'b11; BGACK_n = 1'b1;
        tick(3);
        tests++;
        if (BG_n !== 2'b11) begin fails++; $display("FAIL reset_bg: got %b want 11", BG_n); end
        tests++;
        if (CPU_OWNS_BUS !== 1'b1) begin fails++; $display("FAIL reset_cpu: got %b want 1", CPU_OWNS_BUS); end
        tests++;
        if (OWNER !== 1'b0 || GRANT_TIMEOUT !== 1'b0) begin
            fails++; $display("FAIL reset_owner_gt: got owner=%b gt=%b want 0 0", OWNER, GRANT_TIMEOUT);
        end
        RESET_n = 1'b1;
        tick(2);
    endtask

    task automatic test_single;
        BR_n = 2'b10;
        for (int i = 1; i <= 3; i++) begin
            tick(1);
            tests++;
            if (BG_n !== 2'b11) begin fails++; $display("FAIL single_early_bg edge %0d: got %b want 11", i, BG_n); end
        end
        tick(1);
        tests++;
        if (BG_n !== 2'b10 || OWNER !== 1'b0 || CPU_OWNS_BUS !== 1'b1) begin
            fails++; $display("FAIL single_grant: got bg=%b owner=%b cpu=%b want 10 0 1", BG_n, OWNER, CPU_OWNS_BUS);
        end
        BGACK_n = 1'b0; BR_n = 2'b11;
        tick(2);
        tests++;
        if (BG_n !== 2'b10) begin fails++; $display("FAIL single_ack_early: got %b want 10", BG_n); end
        tick(1);
        tests++;
        if (BG_n !== 2'b11 || CPU_OWNS_BUS !== 1'b0) begin
            fails++; $display("FAIL single_owned: got bg=%b cpu=%b want 11 0", BG_n, CPU_OWNS_BUS);
        end
        tick(3);
        BGACK_n = 1'b1;
        tick(3);
        tests++;
        if (CPU_OWNS_BUS !== 1'b0) begin fails++; $display("FAIL single_recover_early: got cpu=%b want 0", CPU_OWNS_BUS); end
        tick(1);
        tests++;
        if (CPU_OWNS_BUS !== 1'b1 || BG_n !== 2'b11) begin
            fails++; $display("FAIL single_release: got cpu=%b bg=%b want 1 11", CPU_OWNS_BUS, BG_n);
        end
        tick(2);
    endtask

    task automatic test_as_hold;
        int held_ok;
        held_ok = 1;
        AS_n = 1'b0; BR_n = 2'b01;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (BG_n !== 2'b11) held_ok = 0;
        end
        tests++;
        if (held_ok != 1) begin fails++; $display("FAIL as_hold_bg: got grant while AS_n low, want 11 throughout"); end
        AS_n = 1'b1;
        tick(1);
        tests++;
        if (BG_n !== 2'b01 || OWNER !== 1'b1) begin
            fails++; $display("FAIL as_release_grant: got bg=%b owner=%b want 01 1", BG_n, OWNER);
        end
        BR_n = 2'b11;
        tick(4);
        tests++;
        if (BG_n !== 2'b11 || GRANT_TIMEOUT !== 1'b0) begin
            fails++; $display("FAIL as_cleanup: got bg=%b gt=%b want 11 0", BG_n, GRANT_TIMEOUT);
        end
    endtask

    task automatic test_timeout;
        int low_ok;
        low_ok = 1;
        BR_n = 2'b10;
        tick(4);
        tests++;
        if (BG_n !== 2'b10) begin fails++; $display("FAIL timeout_grant: got %b want 10", BG_n); end
        for (int i = 1; i <= 15; i++) begin
            tick(1);
            if (BG_n !== 2'b10 || GRANT_TIMEOUT !== 1'b0) low_ok = 0;
            if (i == 14) BR_n = 2'b11;
        end
        tests++;
        if (low_ok != 1) begin fails++; $display("FAIL timeout_hold: grant dropped or pulse early, want bg=10 gt=0 for 15 edges"); end
        tick(1);
        tests++;
        if (BG_n !== 2'b11 || GRANT_TIMEOUT !== 1'b1) begin
            fails++; $display("FAIL timeout_pulse: got bg=%b gt=%b want 11 1", BG_n, GRANT_TIMEOUT);
        end
        tick(1);
        tests++;
        if (GRANT_TIMEOUT !== 1'b0 || BG_n !== 2'b11 || CPU_OWNS_BUS !== 1'b1) begin
            fails++; $display("FAIL timeout_after: got gt=%b bg=%b cpu=%b want 0 11 1", GRANT_TIMEOUT, BG_n, CPU_OWNS_BUS);
        end
        tick(3);
        tests++;
        if (BG_n !== 2'b11) begin fails++; $display("FAIL timeout_idle: got %b want 11", BG_n); end
    endtask

    task automatic test_withdraw;
        BR_n = 2'b10;
        tick(4);
        tests++;
        if (BG_n !== 2'b10) begin fails++; $display("FAIL withdraw_grant: got %b want 10", BG_n); end
        tick(2);
        BR_n = 2'b11;
        tick(2);
        tests++;
        if (BG_n !== 2'b10) begin fails++; $display("FAIL withdraw_early: got %b want 10", BG_n); end
        tick(1);
        tests++;
        if (BG_n !== 2'b11 || GRANT_TIMEOUT !== 1'b0 || CPU_OWNS_BUS !== 1'b1) begin
            fails++; $display("FAIL withdraw_release: got bg=%b gt=%b cpu=%b want 11 0 1", BG_n, GRANT_TIMEOUT, CPU_OWNS_BUS);
        end
        tick(1);
        tests++;
        if (GRANT_TIMEOUT !== 1'b0) begin fails++; $display("FAIL withdraw_no_pulse: got gt=%b want 0", GRANT_TIMEOUT); end
        tick(2);
    endtask

    task automatic test_tie;
        logic [2:0] exp_owner;
        int         waited;
`ifdef BUS_ARB_ROUND_ROBIN_EN
        exp_owner = 3'b010;
`else
        exp_owner = 3'b000;
`endif
        BR_n = 2'b00;
        for (int k = 0; k < 3; k++) begin
            waited = 0;
            while (BG_n === 2'b11 && waited < 20) begin
                tick(1);
                waited++;
            end
            tests++;
            if (waited >= 20) begin
                fails++; $display("FAIL tie_wait_%0d: got no grant within 20 edges, want grant", k);
            end else if (OWNER !== exp_owner[k] || BG_n !== (exp_owner[k] ? 2'b01 : 2'b10)) begin
                fails++; $display("FAIL tie_owner_%0d: got owner=%b bg=%b want owner=%b", k, OWNER, BG_n, exp_owner[k]);
            end
            BGACK_n = 1'b0;
            tick(3);
            tests++;
            if (CPU_OWNS_BUS !== 1'b0 || BG_n !== 2'b11) begin
                fails++; $display("FAIL tie_owned_%0d: got cpu=%b bg=%b want 0 11", k, CPU_OWNS_BUS, BG_n);
            end
            tick(2);
            BGACK_n = 1'b1;
            if (k == 2) BR_n = 2'b11;
            tick(4);
            tests++;
            if (CPU_OWNS_BUS !== 1'b1) begin fails++; $display("FAIL tie_release_%0d: got cpu=%b want 1", k, CPU_OWNS_BUS); end
        end
        tick(6);
        tests++;
        if (BG_n !== 2'b11 || CPU_OWNS_BUS !== 1'b1) begin
            fails++; $display("FAIL tie_quiet: got bg=%b cpu=%b want 11 1", BG_n, CPU_OWNS_BUS);
        end
    endtask

    task automatic test_reset_mid_owned;
        BR_n = 2'b01;
        tick(4);
        BGACK_n = 1'b0;
        tick(3);
        tests++;
        if (CPU_OWNS_BUS !== 1'b0 || OWNER !== 1'b1) begin
            fails++; $display("FAIL mid_owned_setup: got cpu=%b owner=%b want 0 1", CPU_OWNS_BUS, OWNER);
        end
        #2;
        RESET_n = 1'b0;
        #1;
        tests++;
        if (BG_n !== 2'b11 || CPU_OWNS_BUS !== 1'b1 || GRANT_TIMEOUT !== 1'b0 || OWNER !== 1'b0) begin
            fails++; $display("FAIL mid_owned_reset: got bg=%b cpu=%b gt=%b owner=%b want 11 1 0 0",
                              BG_n, CPU_OWNS_BUS, GRANT_TIMEOUT, OWNER);
        end
        BR_n = 2'b11; BGACK_n = 1'b1;
        tick(2);
        RESET_n = 1'b1;
        tick(4);
        tests++;
        if (BG_n !== 2'b11 || CPU_OWNS_BUS !== 1'b1) begin
            fails++; $display("FAIL mid_owned_after: got bg=%b cpu=%b want 11 1", BG_n, CPU_OWNS_BUS);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset;
        test_single;
        test_as_hold;
        test_timeout;
        test_withdraw;
        test_tie;
        test_reset_mid_owned;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_3w.md
# bus_arbiter_3w

Three-wire 68000-style bus arbitration responder for the card's local bus. It accepts bus requests from two local DMA masters (e.g. SDIO DMA, debug/copy engine) and issues per-master bus grants. It watches the shared BGACK_n line and decides when the 68SEC000 must tri-state its bus drivers. It is the grant side of the BR/BG/BGACK handshake that the card's top level performs as a requester toward the motherboard.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: C7M cycles allowed between BG assertion and BGACK_n assertion before the grant is withdrawn; legal range 2..255.

Ports:
- C7M  input  1  7 MHz bus clock; all state changes on rising edge.
- RESET_n  input  1  reset, asynchronous, active-low.
- AS_n  input  1  address strobe of current bus master, synchronous to C7M, sampled directly.
- BR_n  input  2  bus requests, active-low, bit 0 = master 0; asynchronous.
- BGACK_n  input  1  wired bus-grant-acknowledge, active-low; asynchronous.
- BG_n  output  2  per-master bus grant, active-low, registered.
- CPU_OWNS_BUS  output  1  high = CPU may drive address/strobes; registered.
- OWNER  output  1  index of the granted/owning master; valid when BG_n or ACK state active.
- GRANT_TIMEOUT  output  1  one-cycle high pulse when a grant is withdrawn for timeout.

## Operation
- BR_n[1:0] and BGACK_n pass through 2-flop synchronizers (br_s, bgack_s). AS_n is used unsynchronized.
- State machine states: IDLE, WAIT_AS, GRANT, OWNED, RECOVER.
- IDLE: CPU_OWNS_BUS=1, BG_n=2'b11. If any br_s is low, latch the winner into OWNER and go to WAIT_AS.
- WAIT_AS: when AS_n is high, go to GRANT and assert BG_n[OWNER] low.
- GRANT: BG_n[OWNER] stays low and a timeout counter runs.
  - bgack_s low: negate BG_n, set CPU_OWNS_BUS=0, go to OWNED.
  - br_s[OWNER] high with bgack_s still high (request withdrawn): negate BG_n, go to IDLE.
  - Counter reaches TIMEOUT_CYCLES: negate BG_n, pulse GRANT_TIMEOUT, go to IDLE.
  - Priority when several are true in the same cycle: bgack > withdraw > timeout.
- OWNED: CPU_OWNS_BUS=0, BG_n=11. New requests are ignored. When bgack_s goes high, go to RECOVER.
- RECOVER: one cycle with CPU_OWNS_BUS=0, then go to IDLE and set CPU_OWNS_BUS=1. This cycle is the bus turnaround.
- Winner selection with both requests active: master 0 wins (see Configuration).
- Timeout counter: 8-bit. It clears on entry to GRANT and saturates; it does not wrap.
- Reset, asynchronous and valid mid-operation: state IDLE, BG_n=2'b11, CPU_OWNS_BUS=1, OWNER=0, GRANT_TIMEOUT=0, synchronizers preset to 1, counter 0, round-robin pointer 0.

## Timing
- All outputs are registered and change only on a C7M rising edge.
- Request to grant: BR_n low sampled at edge k, with AS_n high and the state IDLE:
  - edge k+2: br_s is low.
  - edge k+3: state is WAIT_AS.
  - edge k+4: BG_n low.
- If AS_n is low, BG_n is held off until the first edge after AS_n is sampled high.
- BGACK to release: BGACK_n low at edge m gives BG_n high and CPU_OWNS_BUS=0 at edge m+3 (2 synchronizer cycles plus 1 state cycle).
- End of ownership: BGACK_n high at edge n gives CPU_OWNS_BUS=1 at edge n+4.
- GRANT_TIMEOUT asserts on the same edge BG_n negates and is high for exactly one cycle.
- Minimum spacing between two grants: 2 cycles of IDLE/WAIT_AS after RECOVER.

## Configuration
- Macro BUS_ARB_ROUND_ROBIN_EN.
  - Defined: a 1-bit pointer selects which master wins a tie. After a master completes OWNED, the pointer moves to the other master. Timeout or withdraw does not move it.
  - Undefined: fixed priority, master 0 always wins a tie. No pointer register exists.

## Test plan
- Single request: BR_n=10, AS_n high → BG_n=10 four edges later, OWNER=0. BGACK_n low → BG_n=11 and CPU_OWNS_BUS=0 three edges later. BGACK_n high → CPU_OWNS_BUS=1 four edges later.
- AS_n held low 10 cycles while BR_n=01 → BG_n stays 11 until the first edge after AS_n rises, then BG_n=01, OWNER=1.
- Timeout: BR_n=10, BGACK_n never asserted, TIMEOUT_CYCLES=16 → BG_n low for 16 cycles, then BG_n=11 plus a one-cycle GRANT_TIMEOUT pulse, state IDLE.
- Withdraw: BR_n=10 granted, BR_n back to 11 before BGACK → BG_n=11 three edges later, no GRANT_TIMEOUT, CPU_OWNS_BUS stays 1.
- Tie: BR_n=00 held across three complete ownerships → fixed priority gives OWNER 0,0,0; with BUS_ARB_ROUND_ROBIN_EN gives 0,1,0.
- Reset mid-OWNED: RESET_n low asynchronously → BG_n=11, CPU_OWNS_BUS=1, GRANT_TIMEOUT=0 immediately, with no clock edge needed.
